// File: rtl/led_chaser_decoder.sv
// Registered one-hot LED decoder with a prescaled running-light position counter.
// Latency: sel->y one clk in DIRECT mode. Backpressure: none; the LED bank is always ready.
// Optional LED_CHASER_TRAIL_EN: two-LED trail (current plus previous position) in RUN_UP/RUN_DN.
module led_chaser_decoder #(
   parameter int SEL_W      = 3,
   parameter int DIV_W      = 26,
   parameter int DIV_MAX    = 49_999_999,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    load,
   output logic [(2**SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]        pos,
   output logic                    tick
);

   localparam int OUT_W = 2**SEL_W;

   localparam logic [1:0] MODE_DIRECT    = 2'b00;
   localparam logic [1:0] MODE_RUN_UP    = 2'b01;
   localparam logic [1:0] MODE_RUN_DN    = 2'b10;
   localparam logic [1:0] MODE_PING_PONG = 2'b11;

   localparam logic [0:0] DIR_UP = 1'b0;
   localparam logic [0:0] DIR_DN = 1'b1;

   localparam logic [SEL_W-1:0] POS_TOP = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] POS_ONE = SEL_W'(1);
   localparam logic [DIV_W-1:0] CNT_TOP = DIV_W'(DIV_MAX);
   localparam logic [OUT_W-1:0] ONE_HOT = OUT_W'(1);
   localparam logic [OUT_W-1:0] Y_IDLE  = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [0:0]       dir;
   logic [0:0]       dir_cur;
   logic [0:0]       dir_nxt;
   logic [1:0]       mode_q;
   logic [SEL_W-1:0] pos_nxt;
   logic [OUT_W-1:0] lit;
   logic             run;
   logic             at_top;
   logic             tick_nxt;
   logic             step;

`ifdef LED_CHASER_TRAIL_EN
   logic [SEL_W-1:0] prev_pos;
   logic [SEL_W-1:0] prev_nxt;
`endif

   always_comb begin
      run      = enable && (mode != MODE_DIRECT);
      at_top   = (cnt == CNT_TOP);
      tick_nxt = run && at_top;
      // a load on the terminal-count cycle still strobes tick but suppresses the step
      step     = tick_nxt && !load;
      cnt_nxt  = (!run || load || at_top) ? '0 : cnt + 1'b1;

      dir_cur = ((mode == MODE_PING_PONG) && (mode_q != MODE_PING_PONG)) ? DIR_UP : dir;
      pos_nxt = pos;
      dir_nxt = dir;

      if (!enable) begin
         pos_nxt = pos;
         dir_nxt = dir;
      end else if (load) begin
         pos_nxt = sel;
         dir_nxt = DIR_UP;
      end else if (mode == MODE_DIRECT) begin
         pos_nxt = sel;
         dir_nxt = dir_cur;
      end else begin
         dir_nxt = dir_cur;
         if (step) begin
            case (mode)
               MODE_RUN_UP: pos_nxt = pos + 1'b1;
               MODE_RUN_DN: pos_nxt = pos - 1'b1;
               default: begin
                  // end positions are bounced off, so each end LED is lit for one period only
                  if (dir_cur == DIR_UP) begin
                     if (pos == POS_TOP) begin
                        pos_nxt = POS_TOP - 1'b1;
                        dir_nxt = DIR_DN;
                     end else begin
                        pos_nxt = pos + 1'b1;
                     end
                  end else begin
                     if (pos == '0) begin
                        pos_nxt = POS_ONE;
                        dir_nxt = DIR_UP;
                     end else begin
                        pos_nxt = pos - 1'b1;
                     end
                  end
               end
            endcase
         end
      end

      lit = enable ? (ONE_HOT << pos_nxt) : '0;

`ifdef LED_CHASER_TRAIL_EN
      prev_nxt = prev_pos;
      if (enable) begin
         if (load || (mode == MODE_DIRECT)) begin
            prev_nxt = pos_nxt;
         end else if (step) begin
            prev_nxt = pos;
         end
         if ((mode == MODE_RUN_UP) || (mode == MODE_RUN_DN)) begin
            lit = lit | (ONE_HOT << prev_nxt);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         pos    <= '0;
         dir    <= DIR_UP;
         tick   <= 1'b0;
         mode_q <= MODE_DIRECT;
         y      <= Y_IDLE;
      end else begin
         cnt    <= cnt_nxt;
         pos    <= pos_nxt;
         dir    <= dir_nxt;
         tick   <= tick_nxt;
         mode_q <= enable ? mode : mode_q;
         y      <= lit ^ Y_IDLE;
      end
   end

`ifdef LED_CHASER_TRAIL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pos <= '0;
      end else begin
         prev_pos <= prev_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_led_chaser_decoder.sv
// Bench for led_chaser_decoder: directed vectors, expected outputs queued per cycle and
// compared by an independent monitor; an ACTIVE_LOW=1 twin shares all inputs.
module tb_led_chaser_decoder;

   localparam logic [1:0] DIRECT = 2'b00;
   localparam logic [1:0] UP     = 2'b01;
   localparam logic [1:0] DN     = 2'b10;
   localparam logic [1:0] PP     = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [2:0] sel = 3'd0;
   logic [7:0] y, y_al;
   logic [2:0] pos, pos_al;
   logic       tick, tick_al;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] ey;
      logic [2:0] ep;
      logic       et;
   } exp_t;

   exp_t  sb[$];
   string names[$];

   always #5 clk = ~clk;

   led_chaser_decoder #(.SEL_W(3), .DIV_W(26), .DIV_MAX(3), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .load(load),
      .y(y), .pos(pos), .tick(tick)
   );

   led_chaser_decoder #(.SEL_W(3), .DIV_W(26), .DIV_MAX(3), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .load(load),
      .y(y_al), .pos(pos_al), .tick(tick_al)
   );

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (y,pos,tick packed)", nm, act, req);
      end
   endtask

   function automatic logic [7:0] oh(input int p);
      return 8'h01 << p;
   endfunction

   function automatic logic [7:0] ry(input logic [1:0] md, input int cur, input int prv);
`ifdef LED_CHASER_TRAIL_EN
      if ((md == UP) || (md == DN)) return oh(cur) | oh(prv);
`endif
      return oh(cur) | (8'h00 & oh(prv));
   endfunction

   task automatic cyc(input string nm, input logic en, input logic [1:0] md, input int s,
                      input logic ld, input logic [7:0] ey, input int ep, input logic et);
      exp_t e;
      @(negedge clk);
      enable = en;
      mode   = md;
      sel    = 3'(s);
      load   = ld;
      e.ey = ey;
      e.ep = 3'(ep);
      e.et = et;
      sb.push_back(e);
      names.push_back(nm);
   endtask

   // three idle cycles at cur, then the step cycle to nxt with tick
   task automatic run_step(input string nm, input logic [1:0] md, input int cur, input int nxt,
                           input int prv);
      for (int k = 0; k < 3; k++) cyc(nm, 1'b1, md, 0, 1'b0, ry(md, cur, prv), cur, 1'b0);
      cyc({nm, "_step"}, 1'b1, md, 0, 1'b0, ry(md, nxt, cur), nxt, 1'b1);
   endtask

   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = names.pop_front();
            check(nm, {4'h0, y, pos, tick}, {4'h0, e.ey, e.ep, e.et});
            check({nm, "_al"}, {4'h0, y_al, pos_al, tick_al}, {4'h0, ~e.ey, e.ep, e.et});
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int pp_seq [22] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6};
      int cur;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {4'h0, y, pos, tick}, 16'h0000);
      check("reset_state_al", {4'h0, y_al, pos_al, tick_al}, {4'h0, 8'hFF, 3'd0, 1'b0});
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) cyc("idle", 1'b0, DIRECT, 0, 1'b0, 8'h00, 0, 1'b0);

      for (int i = 0; i < 8; i++) cyc("direct", 1'b1, DIRECT, i, 1'b0, oh(i), i, 1'b0);

      cyc("up_load", 1'b1, UP, 6, 1'b1, oh(6), 6, 1'b0);
      run_step("run_up", UP, 6, 7, 6);
      run_step("run_up_wrap", UP, 7, 0, 6);

      cyc("dn_load", 1'b1, DN, 1, 1'b1, oh(1), 1, 1'b0);
      run_step("run_dn", DN, 1, 0, 1);
      run_step("run_dn_wrap", DN, 0, 7, 1);

      cyc("pp_load", 1'b1, PP, 0, 1'b1, oh(0), 0, 1'b0);
      cur = 0;
      for (int i = 0; i < 22; i++) begin
         run_step("ping_pong", PP, cur, pp_seq[i], cur);
         cur = pp_seq[i];
      end
      for (int k = 0; k < 3; k++) cyc("pp_pre_load", 1'b1, PP, 0, 1'b0, oh(6), 6, 1'b0);
      cyc("pp_load_on_step", 1'b1, PP, 5, 1'b1, oh(5), 5, 1'b1);
      run_step("pp_after_load", PP, 5, 6, 5);

      cyc("hold_load", 1'b1, UP, 3, 1'b1, oh(3), 3, 1'b0);
      for (int k = 0; k < 2; k++) cyc("hold_run", 1'b1, UP, 0, 1'b0, oh(3), 3, 1'b0);
      for (int k = 0; k < 10; k++) cyc("hold_dark", 1'b0, UP, 0, 1'b0, 8'h00, 3, 1'b0);
      run_step("resume", UP, 3, 4, 3);

      @(posedge clk);
      #2;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      check("async_rst", {4'h0, y, pos, tick}, 16'h0000);
      check("async_rst_al", {4'h0, y_al, pos_al, tick_al}, {4'h0, 8'hFF, 3'd0, 1'b0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_step("post_rst", UP, 0, 1, 0);

      cyc("trail_load", 1'b1, UP, 2, 1'b1, oh(2), 2, 1'b0);
      run_step("trail", UP, 2, 3, 2);
      run_step("trail", UP, 3, 4, 2);
      cyc("trail_direct", 1'b1, DIRECT, 7, 1'b0, oh(7), 7, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #3;
      check("drain", 16'(sb.size()), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
